spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI target peripheral on the PBUS; the counterpart of the SPI master, so the core can act as the device end of an SPI link.
- Oversamples the external SCK/CS_N/MOSI on clk_i, shifts 8-bit frames MSB-first, supports all four CPOL/CPHA modes.
- Byte FIFOs (wbit_fifo) buffer received and to-be-transmitted data.
- Register map, word offsets:
  - 0x00 CTRL: [3] cpol, [2] cpha, [0] en.
  - 0x04 STATUS: [6] busy, [5] tx_underrun, [4] rx_overflow, [3] tx_empty, [2] tx_full, [1] rx_empty, [0] rx_full.
  - 0x08 RDATA: read pops RX FIFO.
  - 0x0C WDATA: write pushes TX FIFO.

Parameters:
- FIFO_DEPTH, 8, depth of each of the TX and RX byte FIFOs (power of two).
- IDLE_BYTE, 8'h00, byte shifted out when the TX FIFO is empty at frame start.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  synchronous reset, active-high.
- stb_i  in  1  register access strobe.
- adr_i  in  2  register select (word index).
- byte_sel_i  in  4  byte enables.
- we_i  in  1  1 = write, 0 = read.
- dat_i  in  XLEN  write data.
- dat_o  out  XLEN  read data, combinational from adr_i.
- spi_sck_i  in  1  SPI clock from the master, asynchronous.
- spi_mosi_i  in  1  master-out data, asynchronous.
- spi_cs_n_i  in  1  chip select, active-low, asynchronous.
- spi_miso_o  out  1  target-out data.
- spi_miso_oe_o  out  1  MISO output enable; high while selected and en=1.
- irq_o  out  1  level interrupt: !rx_empty | rx_overflow | tx_underrun.

Behaviour:
- Reset state:
  - CTRL = 0.
  - Sticky bits cleared; both FIFOs emptied; frame state idle.
  - spi_miso_o = 0, spi_miso_oe_o = 0, irq_o = 0.
- Reset mid-frame aborts the frame: no RX push; the partial byte is lost.
- Input synchronisation:
  - sck, cs_n and mosi each pass through a 2-FF synchroniser.
  - Edges are detected against a third registered copy.
  - Sync-to-action latency is 3 clk_i cycles.
  - Requirement: f(clk_i) >= 8 x f(SCK).
- Edge definitions:
  - Leading edge: synced SCK moves away from cpol.
  - Trailing edge: synced SCK returns to cpol.
  - SCK edges are ignored while synced CS_N = 1 or en = 0.
- Frame start (synced CS_N falling, en = 1):
  - cpol/cpha are latched for the whole selection; CTRL writes during selection take effect at the next selection.
  - bit_cnt = 0.
  - shift_out is loaded from the TX FIFO head with a pop in the same cycle. If the TX FIFO is empty, load IDLE_BYTE and set tx_underrun.
  - busy = 1.
- spi_miso_o = shift_out[7] at all times while spi_miso_oe_o = 1; 0 otherwise.
- CPHA=0:
  - Leading edge: sample synced MOSI into shift_in LSB; bit_cnt += 1.
  - Trailing edge: shift_out <<= 1. If this trailing edge ends bit 8, reload shift_out from the TX FIFO instead (pop, or IDLE_BYTE + underrun).
- CPHA=1:
  - Leading edge: shift_out <<= 1, except on the first leading edge of each byte (bit 7 already presented).
  - Trailing edge: sample MOSI; bit_cnt += 1. On the 8th sample, reload shift_out for the next byte and mark the next leading edge as first.
- Byte completion: on the cycle of the 8th sample, push {shift_in[6:0], mosi} to the RX FIFO and wrap bit_cnt to 0. If the RX FIFO is full, drop the byte and set rx_overflow.
- Continuous frames are supported with CS held low across multiple bytes.
- Deselect (synced CS_N rising) mid-byte:
  - Partial RX byte discarded, bit_cnt = 0, busy = 0.
  - The already-popped TX byte is discarded; no FIFO activity.
- Register reads:
  - RDATA read (stb_i & !we_i & byte_sel_i[0]) pops the RX FIFO if not empty.
  - Reading RDATA while empty returns 0 with no pop.
- Register writes:
  - WDATA write with byte_sel_i[0] pushes if not full; writes while full are silently dropped.
  - CTRL write with byte_sel_i[0] updates en/cpha/cpol.
  - STATUS write with byte_sel_i[0]: 1 in bit 4 or bit 5 clears that sticky bit. If a set event and a clear occur in the same cycle, set wins.
- Simultaneous FIFO access: a CPU pop and an engine push to the RX FIFO (or a CPU push and an engine pop to the TX FIFO) in the same cycle are both honoured, per wbit_fifo semantics.
- en = 0 mid-frame behaves as a deselect.

Test Plan:
- Mode 0, TX preloaded 0xA5, master sends 0x3C with SCK = clk/16 -> MISO bits 1,0,1,0,0,1,0,1; RDATA = 0x3C; STATUS rx_empty 1->0->1 after the read; tx_empty = 1.
- Modes 1, 2 and 3, each with TX 0x81 and master 0x7E -> master receives 0x81; RDATA = 0x7E. Repeat with 3 back-to-back bytes under one CS: RX order preserved, 3 TX pops.
- TX FIFO empty at frame start -> MISO shifts IDLE_BYTE (0x00); STATUS[5] = 1; irq_o = 1; writing 0x20 to STATUS clears it; irq_o drops once RX is empty.
- Master sends FIFO_DEPTH+1 = 9 bytes without CPU reads -> first 8 readable in order; 9th dropped; STATUS[4] = 1 and rx_full = 1.
- CS_N deasserted after 4 SCK cycles, then a full byte 0x55 -> no RX push for the partial frame; next RDATA = 0x55; bit alignment correct.
- rst_i asserted for one cycle mid-byte -> all outputs return to reset values next cycle; FIFOs empty; the following frame is received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI target on the register bus. Oversamples SCK/CS_N/MOSI on clk_i and shifts 8-bit frames MSB-first in all four CPOL/CPHA modes.
// Latency: an SCK/CS_N/MOSI change acts 3 clk_i cycles after it arrives (2-FF synchroniser plus an edge register); register reads are combinational.
// Backpressure: a full RX FIFO drops the byte and sets rx_overflow; an empty TX FIFO sends IDLE_BYTE and sets tx_underrun; a WDATA write to a full TX FIFO is dropped.
//
// Ports:
//   clk_i, rst_i             system clock and synchronous active-high reset
//   stb_i, adr_i, byte_sel_i, we_i, dat_i, dat_o
//                            register access; adr_i is the word index (CTRL, STATUS, RDATA, WDATA)
//   spi_sck_i, spi_mosi_i, spi_cs_n_i
//                            asynchronous SPI inputs from the master
//   spi_miso_o, spi_miso_oe_o
//                            target data out and its output enable
//   irq_o                    level interrupt: RX data available, or a sticky error is set

// wbit_fifo: generic byte FIFO. A push and a pop in the same cycle are both honoured.
// Latency: pushed data is visible at the head on the next cycle; rdat shows the head combinationally.
// Backpressure: a push while full is ignored; a pop while empty is ignored.
module wbit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wdat,
    input  logic             pop,
    output logic [WIDTH-1:0] rdat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdat    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module spi_slave #(
    parameter int         XLEN       = 32,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] IDLE_BYTE  = 8'h00
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stb_i,
    input  logic [1:0]      adr_i,
    input  logic [3:0]      byte_sel_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] dat_i,
    output logic [XLEN-1:0] dat_o,
    input  logic            spi_sck_i,
    input  logic            spi_mosi_i,
    input  logic            spi_cs_n_i,
    output logic            spi_miso_o,
    output logic            spi_miso_oe_o,
    output logic            irq_o
);
    // control register and sticky status bits
    logic en, cpha, cpol;
    logic tx_underrun, rx_overflow;

    // synchronisers; the *_s3 copies exist only for edge detection
    logic sck_s1, sck_s2, sck_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic mosi_s1, mosi_s2;

    // frame engine state
    logic       active;
    logic       cpol_l, cpha_l;
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] shift_out;
    logic       first_lead;    // CPHA=1: bit 7 is already on MISO, so skip the shift on the first leading edge
    logic       reload_pend;   // CPHA=0: the next trailing edge loads a fresh byte instead of shifting

    // FIFO interface
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head;
    logic       tx_push, tx_pop, rx_push, rx_pop;

    // bus decode
    logic acc_wr, acc_rd;
    logic ctrl_wr, status_wr, wdata_wr, rdata_rd;

    // engine events
    logic       cs_fall, frame_start, deselect;
    logic       sck_lead, sck_trail, sample_edge, shift_edge;
    logic       byte_done, reload;
    logic [7:0] next_byte;
    logic [6:0] status;

    // data_i bits 31..8 and the upper byte enables carry nothing for this block
    logic unused_bits;
    assign unused_bits = ^{dat_i[XLEN-1:8], byte_sel_i[3:1]};

    assign acc_wr    = stb_i & we_i & byte_sel_i[0];
    assign acc_rd    = stb_i & ~we_i & byte_sel_i[0];
    assign ctrl_wr   = acc_wr & (adr_i == 2'd0);
    assign status_wr = acc_wr & (adr_i == 2'd1);
    assign wdata_wr  = acc_wr & (adr_i == 2'd3);
    assign rdata_rd  = acc_rd & (adr_i == 2'd2);

    assign cs_fall     = cs_s3 & ~cs_s2;
    assign frame_start = cs_fall & en;
    assign deselect    = active & (cs_s2 | ~en);

    // edges only count while selected and enabled; polarity is the one latched at frame start
    assign sck_lead  = active & en & ~cs_s2 & (sck_s2 != cpol_l) & (sck_s3 == cpol_l);
    assign sck_trail = active & en & ~cs_s2 & (sck_s2 == cpol_l) & (sck_s3 != cpol_l);
    assign sample_edge = cpha_l ? sck_trail : sck_lead;
    assign shift_edge  = cpha_l ? sck_lead  : sck_trail;
    assign byte_done   = sample_edge & (bit_cnt == 3'd7);

    // every point that loads shift_out from the TX FIFO
    assign reload    = frame_start
                     | (byte_done & cpha_l)
                     | (shift_edge & ~cpha_l & reload_pend);
    assign next_byte = tx_empty ? IDLE_BYTE : tx_head;

    assign tx_push = wdata_wr;
    assign tx_pop  = reload & ~tx_empty;
    assign rx_push = byte_done;
    assign rx_pop  = rdata_rd & ~rx_empty;

    wbit_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (tx_push),
        .wdat  (dat_i[7:0]),
        .pop   (tx_pop),
        .rdat  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    wbit_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rx_push),
        .wdat  ({shift_in, mosi_s2}),
        .pop   (rx_pop),
        .rdat  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign status = {active, tx_underrun, rx_overflow, tx_empty, tx_full, rx_empty, rx_full};

    always_comb begin
        dat_o = '0;
        case (adr_i)
            2'd0:    dat_o[3:0] = {cpol, cpha, 1'b0, en};
            2'd1:    dat_o[6:0] = status;
            2'd2:    dat_o[7:0] = rx_empty ? 8'h00 : rx_head;
            default: dat_o      = '0;
        endcase
    end

    assign spi_miso_oe_o = active;
    assign spi_miso_o    = active & shift_out[7];
    assign irq_o         = ~rx_empty | rx_overflow | tx_underrun;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en          <= 1'b0;
            cpha        <= 1'b0;
            cpol        <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overflow <= 1'b0;
            sck_s1      <= 1'b0;
            sck_s2      <= 1'b0;
            sck_s3      <= 1'b0;
            cs_s1       <= 1'b1;
            cs_s2       <= 1'b1;
            cs_s3       <= 1'b1;
            mosi_s1     <= 1'b0;
            mosi_s2     <= 1'b0;
            active      <= 1'b0;
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            bit_cnt     <= 3'd0;
            shift_in    <= 7'd0;
            shift_out   <= 8'd0;
            first_lead  <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            sck_s1  <= spi_sck_i;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= spi_cs_n_i;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            mosi_s1 <= spi_mosi_i;
            mosi_s2 <= mosi_s1;

            if (ctrl_wr) begin
                cpol <= dat_i[3];
                cpha <= dat_i[2];
                en   <= dat_i[0];
            end

            // a set event in the same cycle as a clear wins
            if (reload & tx_empty) begin
                tx_underrun <= 1'b1;
            end else if (status_wr & dat_i[5]) begin
                tx_underrun <= 1'b0;
            end
            if (byte_done & rx_full) begin
                rx_overflow <= 1'b1;
            end else if (status_wr & dat_i[4]) begin
                rx_overflow <= 1'b0;
            end

            if (frame_start) begin
                active      <= 1'b1;
                cpol_l      <= cpol;
                cpha_l      <= cpha;
                bit_cnt     <= 3'd0;
                shift_out   <= next_byte;
                first_lead  <= 1'b1;
                reload_pend <= 1'b0;
            end else if (deselect) begin
                // partial byte and any already-popped TX byte are simply abandoned
                active      <= 1'b0;
                bit_cnt     <= 3'd0;
                reload_pend <= 1'b0;
            end else begin
                if (sample_edge) begin
                    shift_in <= {shift_in[5:0], mosi_s2};
                    bit_cnt  <= bit_cnt + 3'd1;   // wraps to 0 after the 8th sample
                    if (byte_done) begin
                        if (cpha_l) begin
                            shift_out  <= next_byte;
                            first_lead <= 1'b1;
                        end else begin
                            reload_pend <= 1'b1;
                        end
                    end
                end
                if (shift_edge) begin
                    if (cpha_l) begin
                        if (first_lead) begin
                            first_lead <= 1'b0;
                        end else begin
                            shift_out <= {shift_out[6:0], 1'b0};
                        end
                    end else if (reload_pend) begin
                        shift_out   <= next_byte;
                        reload_pend <= 1'b0;
                    end else begin
                        shift_out <= {shift_out[6:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives an SPI master and the register bus against spi_slave, scoreboarding MISO bytes and RDATA.
// Latency: SCK runs at clk/16, CS_N setup and hold are 8 clk cycles each.
// Backpressure: FIFO fill levels and sticky bits are modelled with queues and flags.
module tb_spi_slave;
    localparam int         DEPTH = 8;
    localparam logic [7:0] IDLE  = 8'h00;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stb_i;
    logic [1:0]  adr_i;
    logic [3:0]  byte_sel_i;
    logic        we_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        spi_sck_i;
    logic        spi_mosi_i;
    logic        spi_cs_n_i;
    logic        spi_miso_o;
    logic        spi_miso_oe_o;
    logic        irq_o;

    spi_slave #(.XLEN(32), .FIFO_DEPTH(DEPTH), .IDLE_BYTE(IDLE)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stb_i         (stb_i),
        .adr_i         (adr_i),
        .byte_sel_i    (byte_sel_i),
        .we_i          (we_i),
        .dat_i         (dat_i),
        .dat_o         (dat_o),
        .spi_sck_i     (spi_sck_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_cs_n_i    (spi_cs_n_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .irq_o         (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    logic       m_und = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_cpol = 1'b0;
    logic       m_cpha = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {25'd0, 1'b0, m_und, m_ovf,
                tx_q.size() == 0, tx_q.size() == DEPTH,
                rx_q.size() == 0, rx_q.size() == DEPTH};
    endfunction

    function automatic logic [7:0] m_load();
        if (tx_q.size() == 0) begin
            m_und = 1'b1;
            return IDLE;
        end
        return tx_q.pop_front();
    endfunction

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_i);
        stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d; byte_sel_i = 4'hF;
        @(negedge clk_i);
        stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk_i);
        stb_i = 1'b1; we_i = 1'b0; adr_i = a; byte_sel_i = 4'hF;
        #1 d = dat_o;
        @(negedge clk_i);
        stb_i = 1'b0;
    endtask

    task automatic tx_wr(input logic [7:0] b);
        reg_wr(2'd3, {24'd0, b});
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
    endtask

    task automatic st_clr(input logic [7:0] v);
        reg_wr(2'd1, {24'd0, v});
        if (v[4]) m_ovf = 1'b0;
        if (v[5]) m_und = 1'b0;
    endtask

    task automatic chk_status(input string tag);
        logic [31:0] d;
        reg_rd(2'd1, d);
        chk(tag, d, exp_status());
    endtask

    task automatic chk_irq(input string tag);
        @(negedge clk_i);
        chk(tag, {31'd0, irq_o}, {31'd0, (rx_q.size() != 0) | m_und | m_ovf});
    endtask

    task automatic rd_rdata(input string tag);
        logic [31:0] d;
        logic [7:0]  e;
        e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        reg_rd(2'd2, d);
        chk(tag, d, {24'd0, e});
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        m_cpol = pol; m_cpha = pha;
        spi_sck_i = pol;
        repeat (4) @(negedge clk_i);
        reg_wr(2'd0, {28'd0, pol, pha, 1'b0, 1'b1});
    endtask

    task automatic cs_lo();
        @(negedge clk_i);
        spi_cs_n_i = 1'b0;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic cs_hi();
        repeat (8) @(negedge clk_i);
        spi_cs_n_i = 1'b1;
        repeat (8) @(negedge clk_i);
    endtask

    // one SPI master byte (or its first nbits), SCK half period = 8 clk
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!m_cpha) spi_mosi_i = tx[7-i];
            repeat (8) @(negedge clk_i);
            if (!m_cpha) rx = {rx[6:0], spi_miso_o};
            else         spi_mosi_i = tx[7-i];
            spi_sck_i = ~m_cpol;
            repeat (8) @(negedge clk_i);
            if (m_cpha) rx = {rx[6:0], spi_miso_o};
            spi_sck_i = m_cpol;
        end
    endtask

    // n full bytes under one CS: first, first+step, ...
    task automatic send_bytes(input logic [7:0] first, input int n, input logic [7:0] step);
        logic [7:0]  cur, got, b, kk;
        logic [31:0] d;
        cs_lo();
        cur = m_load();
        reg_rd(2'd1, d);
        chk("busy_in_frame", {31'd0, d[6]}, 32'd1);
        chk("miso_oe_in_frame", {31'd0, spi_miso_oe_o}, 32'd1);
        for (int k = 0; k < n; k++) begin
            kk = 8'(k);
            b  = first + kk * step;
            spi_xfer(b, 8, got);
            chk("miso_byte", {24'd0, got}, {24'd0, cur});
            if (rx_q.size() < DEPTH) rx_q.push_back(b);
            else                     m_ovf = 1'b1;
            cur = m_load();
        end
        cs_hi();
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  got;
        rst_i = 1'b1; stb_i = 1'b0; we_i = 1'b0; adr_i = 2'd0; dat_i = '0; byte_sel_i = 4'h0;
        spi_sck_i = 1'b0; spi_mosi_i = 1'b0; spi_cs_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        // reset state
        chk("rst_miso", {31'd0, spi_miso_o}, 32'd0);
        chk("rst_oe", {31'd0, spi_miso_oe_o}, 32'd0);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        reg_rd(2'd0, d);
        chk("rst_ctrl", d, 32'd0);
        chk_status("rst_status");

        // mode 0 single byte
        set_mode(1'b0, 1'b0);
        tx_wr(8'hA5);
        chk_status("m0_status_pre");
        send_bytes(8'h3C, 1, 8'h00);
        chk_status("m0_status_post");
        chk_irq("m0_irq");
        rd_rdata("m0_rdata");
        chk_status("m0_status_read");
        st_clr(8'h30);

        // modes 1..3: single byte, then three back-to-back
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            tx_wr(8'h81);
            send_bytes(8'h7E, 1, 8'h00);
            rd_rdata("mode_rdata");
            st_clr(8'h30);
            tx_wr(8'h11); tx_wr(8'h22); tx_wr(8'h33);
            chk_status("mode_status_pre3");
            send_bytes(8'hC1, 3, 8'h15);
            chk_status("mode_status_post3");
            rd_rdata("mode_rdata3_0");
            rd_rdata("mode_rdata3_1");
            rd_rdata("mode_rdata3_2");
            st_clr(8'h30);
        end

        // TX underrun
        set_mode(1'b0, 1'b0);
        send_bytes(8'h5A, 1, 8'h00);
        chk_status("und_status");
        chk_irq("und_irq");
        st_clr(8'h20);
        chk_status("und_cleared");
        chk_irq("und_irq_rx");
        rd_rdata("und_rdata");
        chk_irq("und_irq_low");

        // RX overflow: 9 bytes with no reads
        send_bytes(8'h01, DEPTH + 1, 8'h01);
        chk_status("ovf_status");
        for (int i = 0; i < DEPTH; i++) rd_rdata("ovf_rdata");
        chk_status("ovf_drained");
        st_clr(8'h30);
        chk_irq("ovf_irq_low");

        // partial frame then full byte
        tx_wr(8'h96); tx_wr(8'hC3);
        cs_lo();
        got = m_load();
        spi_xfer(8'hF0, 4, got);
        cs_hi();
        chk_status("part_status");
        send_bytes(8'h55, 1, 8'h00);
        rd_rdata("part_rdata");
        chk_status("part_empty");
        st_clr(8'h30);

        // reset mid-byte
        tx_wr(8'h12);
        cs_lo();
        got = m_load();
        spi_xfer(8'hAA, 4, got);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("mrst_miso", {31'd0, spi_miso_o}, 32'd0);
        chk("mrst_oe", {31'd0, spi_miso_oe_o}, 32'd0);
        chk("mrst_irq", {31'd0, irq_o}, 32'd0);
        tx_q.delete(); rx_q.delete(); m_und = 1'b0; m_ovf = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        reg_rd(2'd0, d);
        chk("mrst_ctrl", d, 32'd0);
        chk_status("mrst_status");
        spi_cs_n_i = 1'b1;
        repeat (8) @(negedge clk_i);
        set_mode(1'b0, 1'b0);
        tx_wr(8'h34);
        send_bytes(8'h99, 1, 8'h00);
        rd_rdata("mrst_rdata");
        chk_status("mrst_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // hard stop in case a task never returns
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
